div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage; serves DIV/DIVU.
- Radix-2 restoring division, one quotient bit per cycle.
- Responder to EX's start/annul handshake. EX holds the pipeline stall request until ready_o is high, then writes the result to HI/LO.
- Result format: {remainder, quotient} -> {HI, LO}.

Parameters:
- DATA_W, 32, operand width. Iteration count equals DATA_W; result width is 2*DATA_W.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset (`RstEnable).
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU (unsigned).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  `DivStart / `DivStop. EX holds it high until it has consumed the result.
- annul_i  in  1  abort the current operation (EX flush).
- result_o  out  64  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  `DivResultReady / `DivResultNotReady.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high.
  - state = DivFree; result_o = 0; ready_o = 0; cnt = 0; internal dividend/divisor registers = 0.
  - Reset asserted mid-operation aborts the operation with no ready pulse.
- DivFree:
  - start_i=1 and annul_i=0, opdata2_i==0 -> DivByZero.
  - start_i=1 and annul_i=0, otherwise -> DivOn.
    - Latch |op1| and |op2|; magnitudes are used only when signed_div_i=1, raw values otherwise.
    - Latch the sign flags and signed_div_i; set cnt=0.
    - 65-bit working register = {32'b0, |op1|, 1'b0}.
  - Otherwise stay; ready_o=0, result_o=0.
- DivOn, cnt<32, one iteration per cycle:
  - Trial = work[64:32] - {1'b0, divisor}.
  - Trial negative -> work = work<<1.
  - Trial non-negative -> work = {trial[31:0], work[31:0], 1'b1}.
  - cnt = cnt+1.
- DivOn, cnt==32, correction cycle:
  - Quotient = work[31:0]; negated if signed and the operand signs differ.
  - Remainder = work[64:33]; negated if signed and the dividend is negative.
  - Go to DivEnd; latch result_o and set ready_o=1 on this same edge.
- DivOn, annul_i=1 on any cycle -> DivFree next edge; no result, ready_o stays 0.
- DivByZero: next edge -> DivEnd with result_o=0 and ready_o=1. Latency 2 cycles.
- DivEnd:
  - start_i=1 -> hold result_o and keep ready_o=1.
  - start_i=0 -> DivFree next edge; ready_o=0, result_o=0.
  - annul_i is ignored in this state.
- Latency: start sampled at edge N -> ready_o and result_o visible in cycle N+34, stable until start_i drops.
- Operand inputs are don't-care after the start edge. Changes on them mid-operation have no effect.
- Arithmetic corner cases:
  - Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000 (wraps), remainder 0.
  - Remainder sign follows the dividend.

Optional Feature:
- Macro: DIV_FAST_ZERO_EN.
- Defined: in DivFree, when start is accepted, divisor is nonzero and |op1| < |op2| (unsigned compare of the latched magnitudes):
  - Skip DivOn and go directly to DivEnd.
  - result_o = {op1 (original signed value), 32'b0}; ready_o visible at N+2.
- Undefined: every nonzero-divisor operation takes the full 34-cycle path.

Decomposition:
- Shared defines file, alongside the existing pipeline constants:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady 1'b1, DivResultNotReady 1'b0.
  - DivStart 1'b1, DivStop 1'b0.
  - DoubleRegBus (63:0), RegBus (31:0).
- One natural combinational sub-module: div_step. Inputs: 65-bit work register and 32-bit divisor. Outputs: next work register.

Test Plan:
- Unsigned 100/7, start held -> ready_o=1 at N+34, result_o={32'd2, 32'd14}. Drop start -> next cycle ready_o=0, result_o=0.
- Signed -7/2 (0xFFFFFFF9, 0x2) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- Divide by zero, 5/0 -> ready_o=1 at N+2, result_o=0. Holding start keeps ready_o high.
- annul_i pulsed at N+10 -> state DivFree at N+11, ready_o never asserts. A new 9/3 start at N+12 -> ready at N+46, result {0, 3}.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- rst asserted at N+20 mid-DivOn -> next edge all outputs 0 and state DivFree. With DIV_FAST_ZERO_EN defined, 3/10 -> ready at N+2, result {3, 0}.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared divider constants: FSM state encoding, handshake levels and bus types.
package div_unit_pkg;

    // Divider FSM states.
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Handshake levels seen by EX.
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Pipeline bus types.
    typedef logic [31:0] reg_bus_t;
    typedef logic [63:0] double_reg_bus_t;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration on the packed working register.
module div_unit_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W:0] work_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [2*DATA_W:0] work_o
);

    logic [DATA_W:0] trial;

    // Trial-subtract the divisor from the partial remainder; keep it only if non-negative.
    always_comb begin
        trial = work_i[2*DATA_W:DATA_W] - {1'b0, divisor_i};
        if (trial[DATA_W]) begin
            work_o = {work_i[2*DATA_W-1:0], 1'b0};
        end else begin
            work_o = {trial[DATA_W-1:0], work_i[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for EX: start/annul handshake, result {remainder, quotient}.
// Optional macro DIV_FAST_ZERO_EN: when |op1| < |op2| the result {op1, 0} is returned
// after two cycles instead of running all iterations.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int unsigned CntW = $clog2(DATA_W) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W);

    div_state_e state_q, state_d;

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*DATA_W:0]   work_q, work_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                signed_q, signed_d;
    logic                op1_neg_q, op1_neg_d;
    logic                op2_neg_q, op2_neg_d;
    logic [2*DATA_W-1:0] result_q, result_d;
`ifdef DIV_FAST_ZERO_EN
    logic [DATA_W-1:0]   dividend_q, dividend_d;
    logic                fast_q, fast_d;
`endif

    logic                accept;
    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_mag, op2_mag;
    logic [2*DATA_W:0]   step_work;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    assign accept  = (start_i == DivStart) && !annul_i;
    assign op1_neg = signed_div_i && opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i && opdata2_i[DATA_W-1];
    assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

    div_unit_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .work_i   (work_q),
        .divisor_i(divisor_q),
        .work_o   (step_work)
    );

    // Sign correction of the magnitude result; remainder sign follows the dividend.
    always_comb begin
        quot_fix = work_q[DATA_W-1:0];
        rem_fix  = work_q[2*DATA_W:DATA_W+1];
        if (signed_q && (op1_neg_q ^ op2_neg_q)) begin
            quot_fix = -work_q[DATA_W-1:0];
        end
        if (signed_q && op1_neg_q) begin
            rem_fix = -work_q[2*DATA_W:DATA_W+1];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DivFree;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DivFree: begin
                if (accept) begin
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
`ifdef DIV_FAST_ZERO_EN
                    end else if (op1_mag < op2_mag) begin
                        // Quotient is trivially zero; reuse the two-cycle zero path.
                        state_d = DivByZero;
`endif
                    end else begin
                        state_d = DivOn;
                    end
                end
            end
            DivByZero: state_d = DivEnd;
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else if (cnt_q == CntLast) begin
                    state_d = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    // Datapath next-state: operand capture, iteration and result latch.
    always_comb begin
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        op1_neg_d = op1_neg_q;
        op2_neg_d = op2_neg_q;
        result_d  = result_q;
`ifdef DIV_FAST_ZERO_EN
        dividend_d = dividend_q;
        fast_d     = fast_q;
`endif
        unique case (state_q)
            DivFree: begin
                result_d = '0;
                if (accept) begin
                    cnt_d     = '0;
                    work_d    = {{DATA_W{1'b0}}, op1_mag, 1'b0};
                    divisor_d = op2_mag;
                    signed_d  = signed_div_i;
                    op1_neg_d = op1_neg;
                    op2_neg_d = op2_neg;
`ifdef DIV_FAST_ZERO_EN
                    dividend_d = opdata1_i;
                    fast_d     = (opdata2_i != '0) && (op1_mag < op2_mag);
`endif
                end
            end
            DivByZero: begin
`ifdef DIV_FAST_ZERO_EN
                result_d = fast_q ? {dividend_q, {DATA_W{1'b0}}} : '0;
`else
                result_d = '0;
`endif
            end
            DivOn: begin
                if (!annul_i) begin
                    if (cnt_q == CntLast) begin
                        result_d = {rem_fix, quot_fix};
                    end else begin
                        work_d = step_work;
                        cnt_d  = cnt_q + CntW'(1);
                    end
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    result_d = '0;
                end
            end
            default: result_d = '0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            op1_neg_q <= 1'b0;
            op2_neg_q <= 1'b0;
            result_q  <= '0;
`ifdef DIV_FAST_ZERO_EN
            dividend_q <= '0;
            fast_q     <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            op1_neg_q <= op1_neg_d;
            op2_neg_q <= op2_neg_d;
            result_q  <= result_d;
`ifdef DIV_FAST_ZERO_EN
            dividend_q <= dividend_d;
            fast_q     <= fast_d;
`endif
        end
    end

    // Outputs: result is only exposed while parked in DivEnd.
    always_comb begin
        ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
        result_o = (state_q == DivEnd) ? result_q : '0;
    end

endmodule
